// File: rtl/mmu_burst.sv
// mmu_burst: streams operand pairs from memory through the adder in bursts.
// Optional launch-to-finish cycle counter: define EVENT_COUNTER_EN.

module mmu_burst #(
    parameter int MEM_LEN_BITS   = 8,
    parameter int MEM_ADDR_BITS  = 64,
    parameter int MEM_DATA_BITS  = 64,
    parameter int HOST_DATA_BITS = 32,
    parameter int ADDER_BITS     = 8,
    parameter int BURST_LEN      = 4
) (
    input  logic                      clock,
    input  logic                      reset_n,
    output logic                      mem_req_valid,
    output logic                      mem_req_opcode,
    output logic [MEM_LEN_BITS-1:0]   mem_req_len,
    output logic [MEM_ADDR_BITS-1:0]  mem_req_addr,
    output logic                      mem_wr_valid,
    output logic [MEM_DATA_BITS-1:0]  mem_wr_bits,
    input  logic                      mem_rd_valid,
    input  logic [MEM_DATA_BITS-1:0]  mem_rd_bits,
    output logic                      mem_rd_ready,
    input  logic                      launch,
    output logic                      finish,
    output logic                      event_counter_valid,
    output logic [HOST_DATA_BITS-1:0] event_counter_value,
    input  logic [HOST_DATA_BITS-1:0] length,
    input  logic [HOST_DATA_BITS-1:0] a_addr,
    input  logic [HOST_DATA_BITS-1:0] b_addr,
    input  logic [HOST_DATA_BITS-1:0] c_addr,
    output logic                      op_valid,
    output logic [ADDER_BITS-1:0]     a_data,
    output logic [ADDER_BITS-1:0]     b_data,
    input  logic                      res_valid,
    input  logic [ADDER_BITS-1:0]     res_data
);

    localparam int CW = $clog2(BURST_LEN + 1);
    localparam int AW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int HW = HOST_DATA_BITS;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD_A_REQ,
        S_RD_A_DATA,
        S_RD_B_REQ,
        S_RD_B_DATA,
        S_WAIT_RES,
        S_WR_REQ,
        S_WR_DATA,
        S_DONE
    } state_e;

    state_e                state_q, state_d;
    logic [HW-1:0]         remain_q, remain_d;
    logic [HW-1:0]         raddr_a_q, raddr_a_d;
    logic [HW-1:0]         raddr_b_q, raddr_b_d;
    logic [HW-1:0]         waddr_c_q, waddr_c_d;
    logic [CW-1:0]         idx_q, idx_d;
    logic [CW-1:0]         rcnt_q, rcnt_d;
    logic [ADDER_BITS-1:0] a_buf_q [BURST_LEN];
    logic [ADDER_BITS-1:0] a_buf_d [BURST_LEN];
    logic [ADDER_BITS-1:0] c_buf_q [BURST_LEN];
    logic [ADDER_BITS-1:0] c_buf_d [BURST_LEN];

    logic [CW-1:0] n;
    logic [CW-1:0] n_m1;
    logic          last_beat;
    logic          res_take;

    // Current chunk size; remain is stable for the whole chunk.
    always_comb begin
        n = CW'(BURST_LEN);
        if (remain_q < HW'(BURST_LEN)) begin
            n = remain_q[CW-1:0];
        end
        n_m1      = n - CW'(1);
        last_beat = (idx_q == n_m1);
        res_take  = res_valid && (rcnt_q != n) &&
                    ((state_q == S_RD_B_DATA) || (state_q == S_WAIT_RES));
    end

    // Next-state, descriptor bookkeeping and buffer updates.
    always_comb begin
        state_d   = state_q;
        remain_d  = remain_q;
        raddr_a_d = raddr_a_q;
        raddr_b_d = raddr_b_q;
        waddr_c_d = waddr_c_q;
        idx_d     = idx_q;
        rcnt_d    = rcnt_q;
        a_buf_d   = a_buf_q;
        c_buf_d   = c_buf_q;
        if (res_take) begin
            c_buf_d[rcnt_q[AW-1:0]] = res_data;
            rcnt_d = rcnt_q + CW'(1);
        end
        unique case (state_q)
            S_IDLE: begin
                idx_d  = '0;
                rcnt_d = '0;
                if (launch) begin
                    remain_d  = length;
                    raddr_a_d = a_addr;
                    raddr_b_d = b_addr;
                    waddr_c_d = c_addr;
                    state_d   = (length == '0) ? S_DONE : S_RD_A_REQ;
                end
            end
            S_RD_A_REQ: begin
                idx_d   = '0;
                state_d = S_RD_A_DATA;
            end
            S_RD_A_DATA: begin
                if (mem_rd_valid) begin
                    a_buf_d[idx_q[AW-1:0]] = mem_rd_bits[ADDER_BITS-1:0];
                    idx_d = idx_q + CW'(1);
                    if (last_beat) begin
                        idx_d   = '0;
                        state_d = S_RD_B_REQ;
                    end
                end
            end
            S_RD_B_REQ: begin
                state_d = S_RD_B_DATA;
            end
            S_RD_B_DATA: begin
                if (mem_rd_valid) begin
                    idx_d = idx_q + CW'(1);
                    if (last_beat) begin
                        idx_d   = '0;
                        state_d = S_WAIT_RES;
                    end
                end
            end
            S_WAIT_RES: begin
                if (rcnt_d == n) begin
                    state_d = S_WR_REQ;
                end
            end
            S_WR_REQ: begin
                idx_d   = '0;
                rcnt_d  = '0;
                state_d = S_WR_DATA;
            end
            S_WR_DATA: begin
                idx_d = idx_q + CW'(1);
                if (last_beat) begin
                    idx_d     = '0;
                    remain_d  = remain_q - HW'(n);
                    raddr_a_d = raddr_a_q + HW'(n);
                    raddr_b_d = raddr_b_q + HW'(n);
                    waddr_c_d = waddr_c_q + HW'(n);
                    state_d   = (remain_q == HW'(n)) ? S_DONE : S_RD_A_REQ;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control state; reset aborts any job in flight.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            remain_q  <= '0;
            raddr_a_q <= '0;
            raddr_b_q <= '0;
            waddr_c_q <= '0;
            idx_q     <= '0;
            rcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            remain_q  <= remain_d;
            raddr_a_q <= raddr_a_d;
            raddr_b_q <= raddr_b_d;
            waddr_c_q <= waddr_c_d;
            idx_q     <= idx_d;
            rcnt_q    <= rcnt_d;
        end
    end

    // Operand and result buffers carry no reset; they are rewritten every chunk.
    always_ff @(posedge clock) begin
        a_buf_q <= a_buf_d;
        c_buf_q <= c_buf_d;
    end

    // Port outputs decoded from registered state, so reset forces them low at once.
    always_comb begin
        mem_req_valid  = 1'b0;
        mem_req_opcode = 1'b0;
        mem_req_len    = '0;
        mem_req_addr   = '0;
        mem_wr_valid   = 1'b0;
        mem_wr_bits    = '0;
        mem_rd_ready   = 1'b0;
        op_valid       = 1'b0;
        a_data         = '0;
        b_data         = '0;
        finish         = 1'b0;
        unique case (state_q)
            S_RD_A_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_len   = MEM_LEN_BITS'(n_m1);
                mem_req_addr  = MEM_ADDR_BITS'(raddr_a_q);
            end
            S_RD_B_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_len   = MEM_LEN_BITS'(n_m1);
                mem_req_addr  = MEM_ADDR_BITS'(raddr_b_q);
            end
            S_WR_REQ: begin
                mem_req_valid  = 1'b1;
                mem_req_opcode = 1'b1;
                mem_req_len    = MEM_LEN_BITS'(n_m1);
                mem_req_addr   = MEM_ADDR_BITS'(waddr_c_q);
            end
            S_RD_A_DATA: begin
                mem_rd_ready = 1'b1;
            end
            S_RD_B_DATA: begin
                mem_rd_ready = 1'b1;
                if (mem_rd_valid) begin
                    op_valid = 1'b1;
                    a_data   = a_buf_q[idx_q[AW-1:0]];
                    b_data   = mem_rd_bits[ADDER_BITS-1:0];
                end
            end
            S_WR_DATA: begin
                mem_wr_valid = 1'b1;
                mem_wr_bits  = MEM_DATA_BITS'(c_buf_q[idx_q[AW-1:0]]);
            end
            S_DONE: begin
                finish = 1'b1;
            end
            default: begin
                finish = 1'b0;
            end
        endcase
    end

    logic unused_rd_bits;
    assign unused_rd_bits = ^mem_rd_bits[MEM_DATA_BITS-1:ADDER_BITS];

`ifdef EVENT_COUNTER_EN
    logic [HW-1:0] ev_cnt_q, ev_cnt_d;

    // Counts busy cycles; the reported value includes the current cycle.
    always_comb begin
        ev_cnt_d = (state_q == S_IDLE) ? '0 : ev_cnt_q + HW'(1);
    end

    // Cycle counter register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ev_cnt_q <= '0;
        end else begin
            ev_cnt_q <= ev_cnt_d;
        end
    end

    assign event_counter_valid = finish;
    assign event_counter_value = (state_q == S_IDLE) ? '0 : ev_cnt_q + HW'(1);
`else
    assign event_counter_valid = 1'b0;
    assign event_counter_value = '0;
`endif

endmodule

// File: tb/tb_mmu_burst.sv
// tb_mmu_burst: directed bench with a zero-wait memory and a fixed-latency adder.
// Checks request shapes, results, timing and reset abort.

module tb_mmu_burst;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_req_valid;
    logic        mem_req_opcode;
    logic [7:0]  mem_req_len;
    logic [63:0] mem_req_addr;
    logic        mem_wr_valid;
    logic [63:0] mem_wr_bits;
    logic        rd_valid;
    logic [63:0] rd_bits;
    logic        mem_rd_ready;
    logic        launch;
    logic        finish;
    logic        event_counter_valid;
    logic [31:0] event_counter_value;
    logic [31:0] length, a_addr, b_addr, c_addr;
    logic        op_valid;
    logic [7:0]  a_data, b_data;
    logic        res_valid;
    logic [7:0]  res_data;
    logic        res_valid_r;
    logic [7:0]  res_data_r;

    int lat;
    int cyc = 0;
    int nchecks = 0;
    int nerrors = 0;

    logic [63:0] mem  [0:255];
    logic [63:0] wmem [0:255];
    logic        req_op   [0:127];
    logic [7:0]  req_len  [0:127];
    logic [63:0] req_addr [0:127];
    int          req_cyc  [0:127];
    int          req_n = 0;
    int          wr_n = 0;
    int          fin_n = 0;
    int          fin_cyc;
    logic        ev_vld;
    logic [31:0] ev_val;
    logic [63:0] rd_ptr;
    logic [63:0] wptr;
    int          rd_left = 0;
    logic [7:0]  rq  [0:63];
    int          due [0:63];
    int          head = 0;
    int          tail = 0;
    int          last_op;
    int          last_res;

    mmu_burst dut (
        .clock               (clk),
        .reset_n             (rst_n),
        .mem_req_valid       (mem_req_valid),
        .mem_req_opcode      (mem_req_opcode),
        .mem_req_len         (mem_req_len),
        .mem_req_addr        (mem_req_addr),
        .mem_wr_valid        (mem_wr_valid),
        .mem_wr_bits         (mem_wr_bits),
        .mem_rd_valid        (rd_valid),
        .mem_rd_bits         (rd_bits),
        .mem_rd_ready        (mem_rd_ready),
        .launch              (launch),
        .finish              (finish),
        .event_counter_valid (event_counter_valid),
        .event_counter_value (event_counter_value),
        .length              (length),
        .a_addr              (a_addr),
        .b_addr              (b_addr),
        .c_addr              (c_addr),
        .op_valid            (op_valid),
        .a_data              (a_data),
        .b_data              (b_data),
        .res_valid           (res_valid),
        .res_data            (res_data)
    );

    always #5 clk = ~clk;

    assign res_valid = (lat == 0) ? op_valid : res_valid_r;
    assign res_data  = (lat == 0) ? 8'(a_data + b_data) : res_data_r;

    // Adder pipeline input side and cycle bookkeeping.
    always @(posedge clk) begin
        if (op_valid) begin
            last_op = cyc;
            if (lat != 0) begin
                rq[tail % 64]  = 8'(a_data + b_data);
                due[tail % 64] = cyc + lat;
                tail++;
            end
        end
        if (res_valid) last_res = cyc;
        cyc++;
    end

    // Memory model, request log, adder output side.
    always @(negedge clk) begin
        if (!rst_n) begin
            rd_left     = 0;
            rd_valid    = 1'b0;
            res_valid_r = 1'b0;
            head        = tail;
        end else begin
            if (mem_req_valid) begin
                req_op[req_n]   = mem_req_opcode;
                req_len[req_n]  = mem_req_len;
                req_addr[req_n] = mem_req_addr;
                req_cyc[req_n]  = cyc;
                req_n++;
                if (!mem_req_opcode) begin
                    rd_ptr  = mem_req_addr;
                    rd_left = int'(mem_req_len) + 1;
                end else begin
                    wptr = mem_req_addr;
                end
            end
            if (mem_rd_ready && rd_left > 0) begin
                rd_valid = 1'b1;
                rd_bits  = mem[rd_ptr[7:0]];
                rd_ptr++;
                rd_left--;
            end else begin
                rd_valid = 1'b0;
            end
            if (mem_wr_valid) begin
                wmem[wptr[7:0]] = mem_wr_bits;
                wptr++;
                wr_n++;
            end
            if (finish) begin
                fin_n++;
                fin_cyc = cyc;
                ev_vld  = event_counter_valid;
                ev_val  = event_counter_value;
            end
            if (head != tail && due[head % 64] <= cyc) begin
                res_valid_r = 1'b1;
                res_data_r  = rq[head % 64];
                head++;
            end else begin
                res_valid_r = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nerrors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_job(input int len, input int l, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] c,
                           output int delta);
        int lc;
        int f0;
        lat    = l;
        length = len;
        a_addr = a;
        b_addr = b;
        c_addr = c;
        @(negedge clk);
        launch = 1'b1;
        lc     = cyc;
        f0     = fin_n;
        @(negedge clk);
        launch = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            #1;
            if (fin_n != f0) break;
        end
        repeat (4) @(posedge clk);
        #1;
        check("finish_pulses", 64'(fin_n - f0), 64'd1);
        delta = fin_cyc - lc;
`ifdef EVENT_COUNTER_EN
        check("ev_valid", 64'(ev_vld), 64'd1);
        check("ev_value", 64'(ev_val), 64'(delta));
`else
        check("ev_valid", 64'(ev_vld), 64'd0);
        check("ev_value", 64'(ev_val), 64'd0);
`endif
    endtask

    initial begin
        int r0;
        int w0;
        int f0;
        int d;
        rst_n  = 1'b0;
        launch = 1'b0;
        length = '0;
        a_addr = '0;
        b_addr = '0;
        c_addr = '0;
        lat    = 1;
        for (int i = 0; i < 256; i++) mem[i] = 64'hFFFF_0000_0000_0000;
        repeat (3) @(negedge clk);
        #1;
        check("rst_outs", {2'b0, mem_req_valid, mem_req_opcode, mem_req_len,
              mem_req_addr[31:0], mem_wr_valid, mem_rd_ready, finish,
              op_valid, a_data, b_data}, 64'd0);
        check("rst_wr_bits", mem_wr_bits, 64'd0);
        check("rst_ev", {31'b0, event_counter_valid, event_counter_value},
              64'd0);
        rst_n = 1'b1;

        // len=3: single chunk, 8-bit operands taken from low beat bits
        mem[8'h10] = 64'hAB00_0000_0000_0001;
        mem[8'h11] = 64'hAB00_0000_0000_0002;
        mem[8'h12] = 64'hAB00_0000_0000_0003;
        mem[8'h40] = 64'hCD00_0000_0000_000A;
        mem[8'h41] = 64'hCD00_0000_0000_0014;
        mem[8'h42] = 64'hCD00_0000_0000_001E;
        r0 = req_n;
        w0 = wr_n;
        run_job(3, 1, 32'h10, 32'h40, 32'h80, d);
        check("j1_nreq", 64'(req_n - r0), 64'd3);
        check("j1_ops", {61'b0, req_op[r0], req_op[r0+1], req_op[r0+2]},
              64'b001);
        check("j1_lens", {40'b0, req_len[r0], req_len[r0+1], req_len[r0+2]},
              64'h020202);
        check("j1_addr_a", req_addr[r0], 64'h10);
        check("j1_addr_b", req_addr[r0+1], 64'h40);
        check("j1_addr_c", req_addr[r0+2], 64'h80);
        check("j1_nwr", 64'(wr_n - w0), 64'd3);
        check("j1_c0", wmem[8'h80], 64'd11);
        check("j1_c1", wmem[8'h81], 64'd22);
        check("j1_c2", wmem[8'h82], 64'd33);
        check("j1_delta", 64'(d), 64'd14);

        // len=10: chunks 4,4,2
        for (int i = 0; i < 10; i++) begin
            mem[8'h10 + i] = 64'h1200_0000_0000_0000 | 64'(i + 1);
            mem[8'h40 + i] = 64'h3400_0000_0000_0000 | 64'(10 * (i + 1));
        end
        r0 = req_n;
        run_job(10, 2, 32'h10, 32'h40, 32'h80, d);
        check("j2_nreq", 64'(req_n - r0), 64'd9);
        check("j2_w0", {req_op[r0+2], req_len[r0+2], req_addr[r0+2][7:0]},
              {1'b1, 8'd3, 8'h80});
        check("j2_w1", {req_op[r0+5], req_len[r0+5], req_addr[r0+5][7:0]},
              {1'b1, 8'd3, 8'h84});
        check("j2_w2", {req_op[r0+8], req_len[r0+8], req_addr[r0+8][7:0]},
              {1'b1, 8'd1, 8'h88});
        check("j2_a2", {req_len[r0+6], req_addr[r0+6][7:0]}, {8'd1, 8'h18});
        for (int i = 0; i < 10; i++) begin
            check("j2_res", wmem[8'h80 + i], 64'(11 * (i + 1)));
        end

        // len=0: no traffic, immediate finish
        r0 = req_n;
        run_job(0, 1, 32'h10, 32'h40, 32'h80, d);
        check("j3_nreq", 64'(req_n - r0), 64'd0);
        check("j3_delta", 64'(d), 64'd1);

        // latency 3, with 8-bit wraparound in the adder
        mem[8'h10] = 64'd200;
        mem[8'h11] = 64'd250;
        mem[8'h12] = 64'd1;
        mem[8'h13] = 64'd128;
        mem[8'h40] = 64'd100;
        mem[8'h41] = 64'd10;
        mem[8'h42] = 64'd255;
        mem[8'h43] = 64'd128;
        r0 = req_n;
        run_job(4, 3, 32'h10, 32'h40, 32'h90, d);
        check("j4_wr_after_last_res", 64'(req_cyc[r0+2] - last_res), 64'd1);
        check("j4_c0", wmem[8'h90], 64'd44);
        check("j4_c1", wmem[8'h91], 64'd4);
        check("j4_c2", wmem[8'h92], 64'd0);
        check("j4_c3", wmem[8'h93], 64'd0);

        // latency 0: WAIT_RES lasts a single cycle
        mem[8'h10] = 64'd7;
        mem[8'h11] = 64'd8;
        mem[8'h40] = 64'd9;
        mem[8'h41] = 64'd10;
        r0 = req_n;
        run_job(2, 0, 32'h10, 32'h40, 32'h98, d);
        check("j5_wr_gap", 64'(req_cyc[r0+2] - last_res), 64'd2);
        check("j5_c0", wmem[8'h98], 64'd16);
        check("j5_c1", wmem[8'h99], 64'd18);

        // a_addr wraps past 2**32 between chunks
        mem[8'hFE] = 64'd5;
        mem[8'hFF] = 64'd6;
        mem[8'h00] = 64'd7;
        mem[8'h01] = 64'd8;
        mem[8'h02] = 64'd9;
        mem[8'h03] = 64'd1;
        for (int i = 0; i < 6; i++) mem[8'h40 + i] = 64'(i + 1);
        r0 = req_n;
        run_job(6, 1, 32'hFFFF_FFFE, 32'h40, 32'hA0, d);
        check("j6_a0_addr", req_addr[r0], 64'h0000_0000_FFFF_FFFE);
        check("j6_a1_addr", req_addr[r0+3], 64'h2);
        check("j6_w1_addr", req_addr[r0+5], 64'hA4);
        check("j6_c3", wmem[8'hA3], 64'd12);
        check("j6_c5", wmem[8'hA5], 64'd7);

        // reset during RD_B_DATA aborts without finish
        lat    = 1;
        length = 32'd4;
        a_addr = 32'h10;
        b_addr = 32'h40;
        c_addr = 32'hB0;
        f0     = fin_n;
        @(negedge clk);
        launch = 1'b1;
        @(negedge clk);
        launch = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (op_valid) break;
        end
        check("rst_reach_rdb", 64'(op_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_outs", {59'b0, op_valid, mem_rd_ready, mem_req_valid,
              mem_wr_valid, finish}, 64'd0);
        check("rst_mid_a", 64'(a_data), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("rst_no_finish", 64'(fin_n - f0), 64'd0);

        mem[8'h10] = 64'd3;
        mem[8'h11] = 64'd4;
        mem[8'h12] = 64'd5;
        mem[8'h40] = 64'd30;
        mem[8'h41] = 64'd40;
        mem[8'h42] = 64'd50;
        run_job(3, 1, 32'h10, 32'h40, 32'hC0, d);
        check("j7_c0", wmem[8'hC0], 64'd33);
        check("j7_c2", wmem[8'hC2], 64'd55);
        check("j7_delta", 64'(d), 64'd14);

        // len=1 with a latency-0 adder: launch-to-finish cycle count
        mem[8'h10] = 64'd1;
        mem[8'h40] = 64'd2;
        run_job(1, 0, 32'h10, 32'h40, 32'hD0, d);
        check("j8_delta", 64'(d), 64'd8);
        check("j8_c0", wmem[8'hD0], 64'd3);

        $display("CHECKS %0d ERRORS %0d", nchecks, nerrors);
        $finish;
    end

endmodule
